wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, default 3, consecutive stalled cycles of port B before B gets priority (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: a_valid  input  1 / a_addr  input  5 / a_data  input  32  port A (pipeline writeback) write request.
REQ-005 SHALL have port: a_ready  output  1  port A request accepted this cycle when a_valid && a_ready.
REQ-006 SHALL have ports: b_valid  input  1 / b_addr  input  5 / b_data  input  32  port B (long-latency unit) write request.
REQ-007 SHALL have port: b_ready  output  1  port B request accepted this cycle when b_valid && b_ready.
REQ-008 SHALL have ports: rf_we  output  1 / rf_wa  output  5 / rf_wd  output  32  register-file write port (we3/wa3/wd3).
REQ-009 SHALL have port: grant_b  output  1  registered; the write currently on rf_* came from port B.

Function
REQ-010 SHALL accept at most one request per cycle; a_ready and b_ready are never both 1 while a_valid && b_valid.
REQ-011 SHALL be combinational for a_ready/b_ready: force_b = (wait_cnt >= STARVE_LIMIT); a_ready = !(b_valid && force_b); b_ready = !a_valid || force_b.
REQ-012 SHALL default to fixed priority for port A when force_b is 0.
REQ-013 SHALL keep wait_cnt (4 bits): +1 on each cycle with b_valid && !b_ready, saturating at 15; cleared on B acceptance or when b_valid is 0.
REQ-014 SHALL register an accepted request into rf_wa/rf_wd on the accepting edge, so it appears on rf_* exactly 1 cycle after acceptance.
REQ-015 SHALL drive rf_we = 1 for exactly one cycle per accepted request, except rf_we = 0 when the accepted addr is 0 (x0 writes are accepted, handshaken, and discarded).
REQ-016 SHALL drive rf_we = 0 in any cycle following a cycle with no acceptance; rf_wa/rf_wd hold their previous values.
REQ-017 SHALL set grant_b registered alongside rf_*: 1 if the accepted request was B, 0 if A, hold when idle.
REQ-018 SHALL emit writes to the register file in acceptance order; back-to-back acceptances yield back-to-back rf_we pulses without bubbles.
REQ-019 SHALL never backpressure from the register-file side; the output register is always free.
REQ-020 SHALL leave requesters responsible for holding addr/data stable while valid && !ready.
REQ-021 SHALL treat B acceptance under force_b as a single grant; wait_cnt clears, so A regains priority on the next cycle.
REQ-022 SHALL grant immediately (no forced stall) when only one port is valid, regardless of wait_cnt.

Reset
REQ-023 SHALL, while rst_n = 0, force rf_we = 0, rf_wa = 0, rf_wd = 0, grant_b = 0, wait_cnt = 0, independent of clk.
REQ-024 SHALL discard a write registered but not yet presented when reset asserts; no rf_we pulse for it after rst_n rises.
REQ-025 SHALL drive a_ready/b_ready per REQ-011 with wait_cnt = 0 during and after reset.

Verification
REQ-026 SHALL cover A-only: a_valid=1, a_addr=5, a_data=0xDEADBEEF one cycle -> a_ready=1; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF, grant_b=0.
REQ-027 SHALL cover x0 discard: b_valid=1, b_addr=0, b_data=0x1234 with a_valid=0 -> b_ready=1; next cycle rf_we=0, grant_b=1.
REQ-028 SHALL cover starvation with STARVE_LIMIT=3: a_valid and b_valid held 1 -> A accepted cycles 0,1,2; cycle 3 b_ready=1, a_ready=0; cycle 4 A accepted again; rf_we continuous with grant_b=1 only in cycle 4.
REQ-029 SHALL cover back-to-back: A writes addr 1,2,3 on consecutive cycles -> three consecutive rf_we pulses, rf_wa 1,2,3 in order.
REQ-030 SHALL cover reset mid-operation: accept A (addr 7) then assert rst_n=0 before next edge -> rf_we=0, rf_wa=0, rf_wd=0 immediately; no write to 7 after release.
REQ-031 SHALL cover wait_cnt clear: b_valid stalled 2 cycles, then b_valid=0 one cycle, then b_valid=1 with a_valid=1 -> B waits a full 3 further cycles before grant.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Two-port register-file writeback arbiter. Port A (pipeline
//                writeback) has fixed priority. Port B (long-latency unit)
//                is forced through after STARVE_LIMIT consecutive stalled
//                cycles. One request is accepted per cycle. The accepted
//                write is registered and presented on rf_* one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
   parameter int STARVE_LIMIT = 3   // legal range 1..15
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_ready,

   input  logic        b_valid,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        b_ready,

   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic        grant_b
);

   // Starvation threshold at the width of the wait counter.
   localparam logic [3:0] LIMIT_W = 4'(STARVE_LIMIT);

   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        rf_we_q,    rf_we_d;
   logic [4:0]  rf_wa_q,    rf_wa_d;
   logic [31:0] rf_wd_q,    rf_wd_d;
   logic        grant_b_q,  grant_b_d;

   logic        force_b;
   logic        a_acc;
   logic        b_acc;

   // Handshake decode: A wins by default, B wins once it has starved long
   // enough. A lone requester is never stalled.
   always_comb begin
      force_b = (wait_cnt_q >= LIMIT_W);
      a_ready = !(b_valid && force_b);
      b_ready = !a_valid || force_b;
      a_acc   = a_valid && a_ready;
      b_acc   = b_valid && b_ready;
   end

   // Next-state for the starvation counter and the output write register.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      rf_we_d    = 1'b0;
      rf_wa_d    = rf_wa_q;
      rf_wd_d    = rf_wd_q;
      grant_b_d  = grant_b_q;

      // The count only measures an unbroken run of B stalls; a dropped
      // valid or a grant starts the run over, so A regains priority.
      if (!b_valid || b_acc) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q != 4'd15) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end

      // x0 writes complete the handshake but never assert the write enable.
      if (b_acc) begin
         rf_we_d   = (b_addr != 5'd0);
         rf_wa_d   = b_addr;
         rf_wd_d   = b_data;
         grant_b_d = 1'b1;
      end else if (a_acc) begin
         rf_we_d   = (a_addr != 5'd0);
         rf_wa_d   = a_addr;
         rf_wd_d   = a_data;
         grant_b_d = 1'b0;
      end
   end

   // State registers; reset clears any write not yet presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= 4'd0;
         rf_we_q    <= 1'b0;
         rf_wa_q    <= 5'd0;
         rf_wd_q    <= 32'd0;
         grant_b_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rf_we_q    <= rf_we_d;
         rf_wa_q    <= rf_wa_d;
         rf_wd_q    <= rf_wd_d;
         grant_b_q  <= grant_b_d;
      end
   end

   assign rf_we   = rf_we_q;
   assign rf_wa   = rf_wa_q;
   assign rf_wd   = rf_wd_q;
   assign grant_b = grant_b_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed, table-driven bench for wb_arbiter (STARVE_LIMIT=3)
//                plus a hand-written reset-in-flight sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        a_valid;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic        b_ready;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        grant_b;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_valid (a_valid),
      .a_addr  (a_addr),
      .a_data  (a_data),
      .a_ready (a_ready),
      .b_valid (b_valid),
      .b_addr  (b_addr),
      .b_data  (b_data),
      .b_ready (b_ready),
      .rf_we   (rf_we),
      .rf_wa   (rf_wa),
      .rf_wd   (rf_wd),
      .grant_b (grant_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  ba;
      logic [31:0] bd;
      logic        ar;   // expected a_ready before the edge
      logic        br;   // expected b_ready before the edge
      logic        we;   // expected rf_* / grant_b after the edge
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        gb;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input string n,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic ar, input logic br,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic gb);
      vec_t v;
      v.name = n;
      v.av = av; v.aa = aa; v.ad = ad;
      v.bv = bv; v.ba = ba; v.bd = bd;
      v.ar = ar; v.br = br;
      v.we = we; v.wa = wa; v.wd = wd; v.gb = gb;
      vecs.push_back(v);
   endtask

   initial begin
      //   name         av aa  ad            bv ba  bd            ar br  we wa  wd            gb
      add("a_only",     1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        1, 0,  1, 5,  32'hDEADBEEF, 0);
      add("idle0",      0, 0,  32'h0,        0, 0,  32'h0,        1, 1,  0, 5,  32'hDEADBEEF, 0);
      add("b_x0",       0, 0,  32'h0,        1, 0,  32'h1234,     1, 1,  0, 0,  32'h1234,     1);
      add("idle1",      0, 0,  32'h0,        0, 0,  32'h0,        1, 1,  0, 0,  32'h1234,     1);
      // starvation: A wins three times, B forced on the fourth, A again after
      add("starve0",    1, 10, 32'hA10,      1, 20, 32'hB20,      1, 0,  1, 10, 32'hA10,      0);
      add("starve1",    1, 11, 32'hA11,      1, 20, 32'hB20,      1, 0,  1, 11, 32'hA11,      0);
      add("starve2",    1, 12, 32'hA12,      1, 20, 32'hB20,      1, 0,  1, 12, 32'hA12,      0);
      add("starve3",    1, 13, 32'hA13,      1, 20, 32'hB20,      0, 1,  1, 20, 32'hB20,      1);
      add("starve4",    1, 13, 32'hA13,      0, 0,  32'h0,        1, 0,  1, 13, 32'hA13,      0);
      add("idle2",      0, 0,  32'h0,        0, 0,  32'h0,        1, 1,  0, 13, 32'hA13,      0);
      // back-to-back A writes
      add("b2b1",       1, 1,  32'h101,      0, 0,  32'h0,        1, 0,  1, 1,  32'h101,      0);
      add("b2b2",       1, 2,  32'h102,      0, 0,  32'h0,        1, 0,  1, 2,  32'h102,      0);
      add("b2b3",       1, 3,  32'h103,      0, 0,  32'h0,        1, 0,  1, 3,  32'h103,      0);
      add("idle3",      0, 0,  32'h0,        0, 0,  32'h0,        1, 1,  0, 3,  32'h103,      0);
      // wait counter cleared by a dropped b_valid
      add("clr0",       1, 4,  32'hA4,       1, 25, 32'hB25,      1, 0,  1, 4,  32'hA4,       0);
      add("clr1",       1, 5,  32'hA5,       1, 25, 32'hB25,      1, 0,  1, 5,  32'hA5,       0);
      add("clr_drop",   1, 6,  32'hA6,       0, 0,  32'h0,        1, 0,  1, 6,  32'hA6,       0);
      add("clr2",       1, 7,  32'hA7,       1, 25, 32'hB25,      1, 0,  1, 7,  32'hA7,       0);
      add("clr3",       1, 8,  32'hA8,       1, 25, 32'hB25,      1, 0,  1, 8,  32'hA8,       0);
      add("clr4",       1, 9,  32'hA9,       1, 25, 32'hB25,      1, 0,  1, 9,  32'hA9,       0);
      add("clr5",       1, 10, 32'hAA,       1, 25, 32'hB25,      0, 1,  1, 25, 32'hB25,      1);
      add("clr6",       1, 10, 32'hAA,       0, 0,  32'h0,        1, 0,  1, 10, 32'hAA,       0);
      // lone B with data, no stall
      add("b_only",     0, 0,  32'h0,        1, 17, 32'hCAFE,     1, 1,  1, 17, 32'hCAFE,     1);
      add("idle4",      0, 0,  32'h0,        0, 0,  32'h0,        1, 1,  0, 17, 32'hCAFE,     1);

      rst_n   = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;

      // Reset values appear before any clock edge.
      #2;
      check("rst_rf_we",   32'(rf_we),   32'd0);
      check("rst_rf_wa",   32'(rf_wa),   32'd0);
      check("rst_rf_wd",   rf_wd,        32'd0);
      check("rst_grant_b", 32'(grant_b), 32'd0);
      check("rst_a_ready", 32'(a_ready), 32'd1);
      check("rst_b_ready", 32'(b_ready), 32'd1);

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
         b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
         #1;
         check({vecs[i].name, ".a_ready"}, 32'(a_ready), 32'(vecs[i].ar));
         check({vecs[i].name, ".b_ready"}, 32'(b_ready), 32'(vecs[i].br));
         @(posedge clk);
         #1;
         check({vecs[i].name, ".rf_we"},   32'(rf_we),   32'(vecs[i].we));
         check({vecs[i].name, ".rf_wa"},   32'(rf_wa),   32'(vecs[i].wa));
         check({vecs[i].name, ".rf_wd"},   rf_wd,        vecs[i].wd);
         check({vecs[i].name, ".grant_b"}, 32'(grant_b), 32'(vecs[i].gb));
      end

      // Reset while an accepted write is on rf_*: cleared asynchronously and
      // never reappears after release.
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
      @(posedge clk);
      #1;
      check("rstmid_we_before", 32'(rf_we), 32'd1);
      check("rstmid_wa_before", 32'(rf_wa), 32'd7);
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      #1;
      rst_n = 1'b0;
      #1;
      check("rstmid_rf_we",   32'(rf_we),   32'd0);
      check("rstmid_rf_wa",   32'(rf_wa),   32'd0);
      check("rstmid_rf_wd",   rf_wd,        32'd0);
      check("rstmid_grant_b", 32'(grant_b), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("rstmid_post_we", 32'(rf_we), 32'd0);
         check("rstmid_post_wa", 32'(rf_wa), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time guard so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
